// File: rtl/wmem_ctrl_if.sv
// Weight-memory controller bus: load stream, read job control and the
// memory-side write/read port, bundled so the controller and its driver
// see one connection.
interface wmem_ctrl_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ROW_NUM       = 6,
    parameter int ADDR_WIDTH    = 7,
    parameter int ROW_WGT_WIDTH = DATA_WIDTH * ROW_NUM,
    parameter int REP_WIDTH     = 4
);
    logic                     i_ld_start;
    logic [ADDR_WIDTH-1:0]    i_ld_base;
    logic [ADDR_WIDTH:0]      i_ld_len;
    logic                     i_ld_valid;
    logic [ROW_WGT_WIDTH-1:0] i_ld_data;
    logic                     o_ld_ready;
    logic                     i_rd_start;
    logic [ADDR_WIDTH-1:0]    i_rd_base;
    logic [ADDR_WIDTH:0]      i_rd_len;
    logic [REP_WIDTH-1:0]     i_rd_rep;
    logic                     i_rd_stall;
    logic                     o_wr_en;
    logic [ADDR_WIDTH-1:0]    o_wr_addr;
    logic [ROW_WGT_WIDTH-1:0] o_wr_data;
    logic                     o_rd_en;
    logic [ADDR_WIDTH-1:0]    o_rd_addr;
    logic                     o_rd_valid;
    logic                     o_rd_last;
    logic                     o_busy;
    logic                     o_done;

    modport master (
        output i_ld_start, i_ld_base, i_ld_len, i_ld_valid, i_ld_data,
        output i_rd_start, i_rd_base, i_rd_len, i_rd_rep, i_rd_stall,
        input  o_ld_ready, o_wr_en, o_wr_addr, o_wr_data,
        input  o_rd_en, o_rd_addr, o_rd_valid, o_rd_last, o_busy, o_done
    );

    modport slave (
        input  i_ld_start, i_ld_base, i_ld_len, i_ld_valid, i_ld_data,
        input  i_rd_start, i_rd_base, i_rd_len, i_rd_rep, i_rd_stall,
        output o_ld_ready, o_wr_en, o_wr_addr, o_wr_data,
        output o_rd_en, o_rd_addr, o_rd_valid, o_rd_last, o_busy, o_done
    );
endinterface

// File: rtl/wmem_ctrl.sv
// Weight-memory controller: streams load beats into the weight memory and
// replays a row window for a number of passes, with a 1-cycle read latency.
//
// state | meaning
// IDLE  | waiting for a start; zero-length starts only pulse done
// LOAD  | accepting load beats, one row written per accepted beat
// READ  | issuing row reads, stall holds the issue
// DRAIN | last row's read data returns, flagged as last
module wmem_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ROW_NUM       = 6,
    parameter int ADDR_WIDTH    = 7,
    parameter int ROW_WGT_WIDTH = DATA_WIDTH * ROW_NUM,
    parameter int REP_WIDTH     = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    wmem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, READ, DRAIN} state_t;

    localparam logic [ADDR_WIDTH:0]  LEN_ONE = 1;
    localparam logic [REP_WIDTH-1:0] REP_ONE = 1;

    state_t                   state_q, state_nxt;
    logic [ADDR_WIDTH-1:0]    base_q, base_nxt;
    logic [ADDR_WIDTH:0]      len_q, len_nxt;
    logic [REP_WIDTH-1:0]     rep_q, rep_nxt;
    logic [ADDR_WIDTH:0]      cnt_q, cnt_nxt;     // beat_count in LOAD, row_idx in READ
    logic [REP_WIDTH-1:0]     pass_q, pass_nxt;
    logic                     done_q, done_nxt;
    logic                     rd_valid_q;

    logic                     run;
    logic                     wr_en, rd_en;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [ROW_WGT_WIDTH-1:0] wr_data;

    // Outputs are forced low while reset is held, even before the state register clears.
    assign run     = ~i_rst;
    assign addr    = base_q + cnt_q[ADDR_WIDTH-1:0];
    assign wr_en   = run & (state_q == LOAD) & bus.i_ld_valid;
    assign rd_en   = run & (state_q == READ) & ~bus.i_rd_stall;
    assign wr_data = wr_en ? bus.i_ld_data : '0;

    assign bus.o_ld_ready = run & (state_q == LOAD);
    assign bus.o_wr_en    = wr_en;
    assign bus.o_wr_addr  = wr_en ? addr : '0;
    assign bus.o_wr_data  = wr_data;
    assign bus.o_rd_en    = rd_en;
    assign bus.o_rd_addr  = rd_en ? addr : '0;
    assign bus.o_rd_valid = run & rd_valid_q;
    assign bus.o_rd_last  = run & rd_valid_q & (state_q == DRAIN);
    assign bus.o_busy     = run & (state_q != IDLE);
    assign bus.o_done     = run & done_q;

    // State, job fields and counters; reset aborts any job without a done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            rep_q      <= '0;
            cnt_q      <= '0;
            pass_q     <= '0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            base_q     <= base_nxt;
            len_q      <= len_nxt;
            rep_q      <= rep_nxt;
            cnt_q      <= cnt_nxt;
            pass_q     <= pass_nxt;
            done_q     <= done_nxt;
            rd_valid_q <= rd_en;
        end
    end

    // Next-state, job latching and counter advance.
    always_comb begin
        state_nxt = state_q;
        base_nxt  = base_q;
        len_nxt   = len_q;
        rep_nxt   = rep_q;
        cnt_nxt   = cnt_q;
        pass_nxt  = pass_q;
        done_nxt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_ld_start) begin
                    if (bus.i_ld_len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = LOAD;
                        base_nxt  = bus.i_ld_base;
                        len_nxt   = bus.i_ld_len;
                        cnt_nxt   = '0;
                    end
                end else if (bus.i_rd_start) begin
                    if (bus.i_rd_len == '0 || bus.i_rd_rep == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = READ;
                        base_nxt  = bus.i_rd_base;
                        len_nxt   = bus.i_rd_len;
                        rep_nxt   = bus.i_rd_rep;
                        cnt_nxt   = '0;
                        pass_nxt  = '0;
                    end
                end
            end
            LOAD: begin
                if (bus.i_ld_valid) begin
                    if (cnt_q == len_q - LEN_ONE) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q + LEN_ONE;
                    end
                end
            end
            READ: begin
                if (!bus.i_rd_stall) begin
                    if (cnt_q == len_q - LEN_ONE) begin
                        cnt_nxt = '0;
                        if (pass_q == rep_q - REP_ONE) begin
                            state_nxt = DRAIN;
                            pass_nxt  = '0;
                        end else begin
                            pass_nxt = pass_q + REP_ONE;
                        end
                    end else begin
                        cnt_nxt = cnt_q + LEN_ONE;
                    end
                end
            end
            DRAIN: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wmem_ctrl.sv
// Bench for wmem_ctrl: directed jobs plus randomized jobs, checked cycle by
// cycle against expected access lists derived from base/len/rep arithmetic.
module tb_wmem_ctrl;

    logic i_clk;
    logic i_rst;
    int   checks = 0;
    int   errors = 0;

    wmem_ctrl_if bus ();

    wmem_ctrl dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input logic er, input logic ew, input logic [6:0] ewa,
                               input logic [47:0] ewd, input logic ere, input logic [6:0] era,
                               input logic ev, input logic el, input logic eb, input logic ed);
        chk("ld_ready", 64'(bus.o_ld_ready), 64'(er));
        chk("wr_en",    64'(bus.o_wr_en),    64'(ew));
        chk("wr_addr",  64'(bus.o_wr_addr),  64'(ewa));
        chk("wr_data",  64'(bus.o_wr_data),  64'(ewd));
        chk("rd_en",    64'(bus.o_rd_en),    64'(ere));
        chk("rd_addr",  64'(bus.o_rd_addr),  64'(era));
        chk("rd_valid", 64'(bus.o_rd_valid), 64'(ev));
        chk("rd_last",  64'(bus.o_rd_last),  64'(el));
        chk("busy",     64'(bus.o_busy),     64'(eb));
        chk("done",     64'(bus.o_done),     64'(ed));
        chk("wr_rd_excl", 64'(bus.o_wr_en & bus.o_rd_en), 64'(0));
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_ld_start = 1'b0;
        bus.i_ld_valid = 1'b0;
        bus.i_rd_start = 1'b0;
        bus.i_rd_stall = 1'b0;
    endtask

    // Load job: expected writes are rows base, base+1, ... modulo 128, one per valid beat.
    task automatic run_load(input logic [6:0] base, input logic [7:0] len,
                            input bit rnd_valid, input bit rd_too);
        int beats = 0;
        int cyc = 0;
        logic v;
        logic [47:0] d;
        logic [6:0] a;
        bus.i_ld_base  = base;
        bus.i_ld_len   = len;
        bus.i_ld_start = 1'b1;
        bus.i_rd_start = rd_too;
        bus.i_rd_base  = 7'($urandom_range(0, 127));
        bus.i_rd_len   = 8'd3;
        bus.i_rd_rep   = 4'd1;
        bus.i_ld_valid = 1'b0;
        #4;
        check_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        bus.i_ld_start = 1'b0;
        while (beats < int'(len) && cyc < 1000) begin
            v = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = {16'($urandom()), $urandom()};
            bus.i_ld_valid = v;
            bus.i_ld_data  = d;
            bus.i_rd_start = rd_too ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.i_ld_start = 1'($urandom_range(0, 1));
            bus.i_rd_stall = 1'($urandom_range(0, 1));
            #4;
            a = 7'((int'(base) + beats) % 128);
            check_cycle(1, v, v ? a : 7'd0, v ? d : 48'd0, 0, 0, 0, 0, 1, 0);
            if (v) beats++;
            cyc++;
            next_cycle();
        end
        idle_inputs();
        #4;
        check_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        next_cycle();
        #4;
        check_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
    endtask

    // Read job: expected issue list is (base + i mod len) mod 128 for i < len*rep.
    task automatic run_read(input logic [6:0] base, input logic [7:0] len, input logic [3:0] rep,
                            input bit rnd, input logic [31:0] mask);
        int n = int'(len) * int'(rep);
        int k = 0;
        int cyc = 0;
        int nvalid = 0;
        logic prev_en = 1'b0;
        logic stall;
        logic [6:0] a;
        bus.i_rd_base  = base;
        bus.i_rd_len   = len;
        bus.i_rd_rep   = rep;
        bus.i_rd_start = 1'b1;
        bus.i_rd_stall = 1'b0;
        #4;
        check_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        bus.i_rd_start = 1'b0;
        while (k < n && cyc < 1000) begin
            stall = rnd ? ($urandom_range(0, 3) == 0) : mask[cyc % 32];
            bus.i_rd_stall = stall;
            bus.i_ld_start = 1'($urandom_range(0, 1));
            bus.i_ld_valid = 1'($urandom_range(0, 1));
            bus.i_rd_start = 1'($urandom_range(0, 1));
            #4;
            a = 7'((int'(base) + (k % int'(len))) % 128);
            check_cycle(0, 0, 0, 0, !stall, stall ? 7'd0 : a, prev_en, 0, 1, 0);
            if (bus.o_rd_valid) nvalid++;
            prev_en = !stall;
            if (!stall) k++;
            cyc++;
            next_cycle();
        end
        chk("rd_issue_budget", 64'(k), 64'(n));
        bus.i_rd_stall = 1'($urandom_range(0, 1));
        bus.i_ld_start = 1'($urandom_range(0, 1));
        #4;
        check_cycle(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        if (bus.o_rd_valid) nvalid++;
        next_cycle();
        idle_inputs();
        #4;
        check_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        next_cycle();
        #4;
        check_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd_valid_count", 64'(nvalid), 64'(n));
        next_cycle();
    endtask

    // Zero-length start: no access, done pulse one cycle later.
    task automatic run_zero(input bit ld, input logic [7:0] len, input logic [3:0] rep);
        bus.i_ld_len   = len;
        bus.i_rd_len   = len;
        bus.i_rd_rep   = rep;
        bus.i_ld_base  = 7'd9;
        bus.i_rd_base  = 7'd9;
        bus.i_ld_start = ld;
        bus.i_rd_start = 1'b1;
        #4;
        check_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        idle_inputs();
        #4;
        check_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        next_cycle();
        #4;
        check_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
    endtask

    initial begin
        i_rst = 1'b1;
        bus.i_ld_base = 7'd0;
        bus.i_ld_len  = 8'd0;
        bus.i_ld_data = 48'd0;
        bus.i_rd_base = 7'd0;
        bus.i_rd_len  = 8'd0;
        bus.i_rd_rep  = 4'd0;
        idle_inputs();

        // Reset: outputs low even with active-looking inputs.
        next_cycle();
        bus.i_ld_valid = 1'b1;
        bus.i_ld_start = 1'b1;
        bus.i_ld_len   = 8'd3;
        #4;
        check_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        idle_inputs();
        i_rst = 1'b0;
        #4;
        check_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        // Load base 5, len 3, valid every cycle.
        run_load(7'd5, 8'd3, 1'b0, 1'b0);
        // Read across the address wrap, two passes.
        run_read(7'd126, 8'd4, 4'd2, 1'b0, 32'd0);
        // Stall held on the second and third READ cycles.
        run_read(7'd0, 8'd3, 4'd1, 1'b0, 32'b110);
        // Both starts together, rd_start kept toggling while loading.
        run_load(7'd120, 8'd12, 1'b1, 1'b1);
        // Zero-length jobs.
        run_zero(1'b0, 8'd0, 4'd2);
        run_zero(1'b0, 8'd4, 4'd0);
        run_zero(1'b1, 8'd0, 4'd2);

        // Reset after two read issues aborts without done.
        bus.i_rd_base  = 7'd10;
        bus.i_rd_len   = 8'd5;
        bus.i_rd_rep   = 4'd1;
        bus.i_rd_start = 1'b1;
        #4;
        check_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        bus.i_rd_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #4;
            check_cycle(0, 0, 0, 0, 1, 7'(10 + i), (i == 1), 0, 1, 0);
            next_cycle();
        end
        i_rst = 1'b1;
        #4;
        check_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        i_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #4;
            check_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            next_cycle();
        end
        run_read(7'($urandom_range(0, 127)), 8'd5, 4'd2, 1'b1, 32'd0);

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            if ($urandom_range(0, 1) == 1)
                run_load(7'($urandom_range(0, 127)), 8'($urandom_range(1, 10)), 1'b1,
                         1'($urandom_range(0, 1)));
            else
                run_read(7'($urandom_range(0, 127)), 8'($urandom_range(1, 8)),
                         4'($urandom_range(1, 3)), 1'b1, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wmem_ctrl.md
WMEM_CTRL -- requirements
Module: wmem_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, weight element bits; ROW_NUM, 6, elements per row; ADDR_WIDTH, 7, weight memory address bits; ROW_WGT_WIDTH, DATA_WIDTH*ROW_NUM, row word bits; REP_WIDTH, 4, read-pass count bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports (name direction width meaning) SHALL be:
- i_clk in 1: clock, all logic on posedge.
- i_rst in 1: synchronous active-high reset.
- i_ld_start in 1: start a load job, sampled in IDLE only.
- i_ld_base in ADDR_WIDTH: first load address.
- i_ld_len in ADDR_WIDTH+1: number of rows to load.
- i_ld_valid in 1: load beat valid.
- i_ld_data in ROW_WGT_WIDTH: load beat row data.
- o_ld_ready out 1: load beat accepted when valid&ready.
- i_rd_start in 1: start a read job, sampled in IDLE only.
- i_rd_base in ADDR_WIDTH: first read address.
- i_rd_len in ADDR_WIDTH+1: rows per pass.
- i_rd_rep in REP_WIDTH: number of passes.
- i_rd_stall in 1: suppress read issue this cycle.
- o_wr_en out 1: memory write enable.
- o_wr_addr out ADDR_WIDTH: memory write address.
- o_wr_data out ROW_WGT_WIDTH: memory write data.
- o_rd_en out 1: memory read enable.
- o_rd_addr out ADDR_WIDTH: memory read address.
- o_rd_valid out 1: memory read data valid this cycle.
- o_rd_last out 1: qualifies final valid row of the job.
- o_busy out 1: state != IDLE.
- o_done out 1: one-cycle job-complete pulse.

Function
REQ-004 FSM states SHALL be IDLE, LOAD, READ, DRAIN.
REQ-005 IDLE transitions:
- i_ld_start=1 -> LOAD; base and len are latched.
- else i_rd_start=1 -> READ; base, len and rep are latched.
- Both starts high: load wins; rd_start is dropped, not queued.
REQ-006 Starts SHALL be ignored outside IDLE.
REQ-007 Zero-length jobs SHALL not enter LOAD/READ: ld len=0, rd len=0 or rep=0 -> stay IDLE, o_done=1 next cycle, no memory access.
REQ-008 LOAD behaviour:
- o_ld_ready=1 in LOAD only.
- o_wr_en = i_ld_valid & o_ld_ready (combinational).
- o_wr_data = i_ld_data.
- o_wr_addr = (base + beat_count) mod 2^ADDR_WIDTH.
- beat_count increments per accepted beat.
REQ-009 Accepting the beat with beat_count = len-1 SHALL move LOAD -> IDLE, with o_done=1 in the following cycle.
REQ-010 READ behaviour:
- o_rd_en = ~i_rd_stall (combinational).
- o_rd_addr = (base + row_idx) mod 2^ADDR_WIDTH.
- row_idx and pass counters advance only on issue.
- row_idx wraps to 0 after len-1 and pass increments.
REQ-011 Issuing the last row of the last pass SHALL move READ -> DRAIN.
REQ-012 o_rd_valid SHALL be o_rd_en registered (1-cycle memory read latency).
REQ-013 o_rd_last SHALL be 1 only with the valid of the job's final row, in DRAIN.
REQ-014 DRAIN SHALL last exactly one cycle, then go to IDLE; o_done=1 in that first IDLE cycle.
REQ-015 Address wrap SHALL be modulo 2^ADDR_WIDTH; len > 2^ADDR_WIDTH-base wraps silently.
REQ-016 o_wr_en and o_rd_en SHALL never be high in the same cycle.
REQ-017 When not asserted, o_wr_addr, o_rd_addr and o_wr_data SHALL hold 0.

Reset
REQ-018 While i_rst=1 the block SHALL:
- force state=IDLE;
- clear all counters and latched job fields;
- hold all outputs at 0, including o_rd_valid.
REQ-019 Reset mid-job SHALL abort the job without an o_done pulse; no memory access occurs in the reset cycle or after it until a new start.

Verification
REQ-020 Load: base=5, len=3, valid on every cycle -> wr_en for 3 cycles at addr 5,6,7; o_done pulses 1 cycle after the 3rd beat.
REQ-021 Read: base=126, len=4, rep=2 -> rd_addr 126,127,0,1,126,127,0,1; 8 rd_valid pulses, each 1 cycle after its rd_en; o_rd_last on the 8th; o_done next cycle.
REQ-022 Stall: read job len=3, stall held on issue cycle 2 -> address 1 repeats only after stall drops; exactly 3 rd_valid pulses total.
REQ-023 Simultaneous ld_start and rd_start in IDLE -> LOAD entered, no read issued; rd_start while busy -> ignored.
REQ-024 Reset mid-READ after 2 issues -> all outputs 0 next cycle, o_done never pulses; a new job then runs normally.
REQ-025 Zero length: rd_len=0 -> o_busy stays 0, no rd_en, o_done=1 next cycle.
